// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction-fetch stage for the 16-bit MIPS pipeline.
// Fetches halfword instructions from a byte-addressed instruction memory,
// buffers them with their PCs in a circular prefetch queue, and hands them
// to decode through a valid/ready handshake. A redirect from EX flushes
// the queue, drops any arriving response, and restarts fetch at the target.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   imem_req/imem_addr  read request and even byte address
//   imem_rdata          instruction returned the cycle after a request
//   out_valid/out_ready handshake for the queue head
//   out_instr/out_pc    head instruction and its byte address
//   redirect_valid/pc   one-cycle redirect from EX (bit 0 of pc ignored)
//   flush_cnt           saturating redirect counter
module mips_fetch_unit #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned IMEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [7:0]  flush_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [15:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [15:0]   inflight_pc_q, inflight_pc_d;
    logic          discard_q, discard_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    flush_q, flush_d;

    logic [15:0]   q_pc    [DEPTH];
    logic [15:0]   q_instr [DEPTH];

    logic          pop, push, issue;
    logic [CW:0]   occ;
    logic [15:0]   pc_seq, target;

    assign out_valid = rst && (count_q != '0);
    assign out_instr = q_instr[rd_q];
    assign out_pc    = q_pc[rd_q];
    assign flush_cnt = flush_q;
    assign imem_addr = pc_q;
    assign imem_req  = issue;

    assign pop  = out_valid && out_ready;
    assign push = inflight_q && !discard_q && !redirect_valid;

    // pop implies count_q >= 1, so the subtraction cannot underflow
    assign occ   = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue = rst && !redirect_valid && (occ < (CW+1)'(DEPTH));

    assign pc_seq = 16'((32'(pc_q) + 32'd2) % IMEM_BYTES);
    assign target = 16'(32'(redirect_pc & 16'hFFFE) % IMEM_BYTES);

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        discard_d     = discard_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        count_d       = count_q;
        flush_d       = flush_q;
        if (redirect_valid) begin
            pc_d    = target;
            // discard follows the new inflight flag; a redirect blocks issue,
            // and the response arriving now is already dropped via push
            discard_d = issue;
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            if (flush_q != 8'hFF)
                flush_d = flush_q + 8'd1;
        end else begin
            if (issue) begin
                inflight_pc_d = pc_q;
                pc_d          = pc_seq;
            end
            if (inflight_q)
                discard_d = 1'b0;
            if (push)
                wr_d = wr_q + AW'(1);
            if (pop)
                rd_d = rd_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            discard_q     <= 1'b0;
            rd_q          <= '0;
            wr_q          <= '0;
            count_q       <= '0;
            flush_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            discard_q     <= discard_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            count_q       <= count_d;
            flush_q       <= flush_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            q_pc[wr_q]    <= inflight_pc_q;
            q_instr[wr_q] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;
    localparam int DEPTH = 4;
    localparam int IMEM  = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [7:0]  flush_cnt;

    mips_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000), .IMEM_BYTES(IMEM)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];

    // Instruction memory: one-cycle read latency, garbage when idle
    always @(posedge clk)
        imem_rdata <= imem_req ? mem[imem_addr[8:1]] : 16'($urandom);

    int checks = 0;
    int errors = 0;

    // Reference model: list of PCs the decode side will see, plus fetch cursor
    bit mok = 0;
    int mpc;
    bit minfl;
    int minfl_pc;
    int mq[$];
    int mfc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rstn, input bit rdy, input bit rv, input logic [15:0] rpc);
        bit pop, issue;
        int occ;
        @(negedge clk);
        rst = rstn; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #1;
        pop = (mq.size() > 0) && rdy;
        occ = mq.size() + int'(minfl) - int'(pop);
        issue = !rv && (occ < DEPTH);
        if (!rstn) begin
            chk("req_in_reset", {31'b0, imem_req}, 0);
            chk("valid_in_reset", {31'b0, out_valid}, 0);
        end else if (mok) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
            if (mq.size() > 0) begin
                chk("out_pc", {16'b0, out_pc}, mq[0]);
                chk("out_instr", {16'b0, out_instr}, {16'b0, mem[mq[0] / 2]});
            end
            chk("imem_req", {31'b0, imem_req}, {31'b0, issue});
            if (issue) chk("imem_addr", {16'b0, imem_addr}, mpc);
            chk("flush_cnt", {24'b0, flush_cnt}, mfc);
        end
        // advance the model across the coming rising edge
        if (!rstn) begin
            mok = 1; mq.delete(); mpc = 0; minfl = 0; mfc = 0;
        end else if (rv) begin
            mq.delete(); minfl = 0;
            mpc = int'(rpc & 16'hFFFE) % IMEM;
            if (mfc < 255) mfc++;
        end else begin
            if (pop) void'(mq.pop_front());
            if (minfl) mq.push_back(minfl_pc);
            checks++;
            assert (mq.size() <= DEPTH) else begin
                errors++;
                $error("FAIL queue_overflow: observed %0d expected <= %0d", mq.size(), DEPTH);
            end
            if (issue) begin
                minfl = 1; minfl_pc = mpc; mpc = (mpc + 2) % IMEM;
            end else minfl = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1025;

        // reset, then streaming with out_ready=1
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("first_req", {31'b0, imem_req}, 1);
        chk("first_addr", {16'b0, imem_addr}, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("first_head_pc", {16'b0, out_pc}, 0);
        chk("first_head_instr", {16'b0, out_instr}, 32'h1025);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

        // backpressure
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        chk("bp_req_stalled", {31'b0, imem_req}, 0);
        chk("bp_head", {16'b0, out_pc}, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

        // redirect with a partly drained queue
        step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 16'h001C);
        step(1, 1, 0, 0);
        chk("redir_bubble", {31'b0, out_valid}, 0);
        chk("redir_fetch", {16'b0, imem_addr}, 32'h1C);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("redir_head", {16'b0, out_pc}, 32'h1C);
        chk("redir_cnt", {24'b0, flush_cnt}, 1);

        // redirect in streaming (response arriving, pop pending), odd target
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        step(1, 1, 1, 16'h0021);
        step(1, 1, 0, 0);
        chk("odd_target", {16'b0, imem_addr}, 32'h20);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

        // wrap, plus back-to-back redirects
        step(1, 1, 1, 16'h0100);
        step(1, 1, 1, 16'h01FE);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
        step(1, 1, 1, 16'hFFFF);
        for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 1) == 1, 0, 0);

        // saturation then mid-stream reset
        for (int i = 0; i < 300; i++) step(1, 1, 1, 16'($urandom));
        step(1, 1, 0, 0);
        chk("flush_sat", {24'b0, flush_cnt}, 255);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_cnt", {24'b0, flush_cnt}, 0);
        chk("rst_refetch", {16'b0, imem_addr}, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 11) == 0, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
